// File: rtl/dice_pkg.sv
// Shared definitions for the DICE host-side BRAM loader: state encoding,
// bram_full flag values and word-to-byte address conversion.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_REF = 3'd1,
    ST_LOAD_DEF = 3'd2,
    ST_FULL     = 3'd3,
    ST_READ     = 3'd4
  } state_e;

  localparam logic [31:0] BRAM_FULL_SET   = 32'h1;
  localparam logic [31:0] BRAM_FULL_CLR   = 32'h0;
  localparam int unsigned BYTE_ADDR_SHIFT = 2;
  localparam logic [3:0]  WE_ALL          = 4'b1111;

  function automatic logic [31:0] byte_addr(input logic [31:0] idx);
    return idx << BYTE_ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Small circular FIFO absorbing result-BRAM read data while the output
// stream is stalled; exposes its occupancy for read-issue throttling.
module bram_rd_skid #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bram_host_loader.sv
// Streams ref/def image words into their BRAMs, flags them resident, then
// reads the result BRAM back through a skid FIFO onto a backpressured stream.
module bram_host_loader
  import dice_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int RES_WORDS = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] ref_addr,
  output logic [31:0] ref_din,
  output logic [3:0]  ref_we,
  output logic        ref_en,
  output logic [31:0] def_addr,
  output logic [31:0] def_din,
  output logic [3:0]  def_we,
  output logic        def_en,
  output logic [31:0] bram_full,
  input  logic        compute_done,
  output logic [31:0] res_addr,
  output logic        res_en,
  input  logic [31:0] res_dout,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int          FIFO_DEPTH = RD_LAT + 2;
  localparam int          CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LD_LAST    = 32'(DEPTH - 1);
  localparam logic [31:0] RD_LAST    = 32'(RES_WORDS - 1);
  localparam logic [31:0] RD_WORDS   = 32'(RES_WORDS);
  localparam logic [7:0]  FIFO_LIM   = 8'(FIFO_DEPTH);

  // Stream protocols: a word moves on a rising edge where valid & ready are
  // both high; valid never waits on ready, and m_data/m_last hold while stalled.
  state_e      state_q, state_d;
  logic [31:0] ld_idx_q, ld_idx_d, rd_idx_q, rd_idx_d, out_idx_q, out_idx_d;
  logic        ref_en_q, ref_en_d, def_en_q, def_en_d;
  logic [3:0]  ref_we_q, ref_we_d, def_we_q, def_we_d;
  logic [31:0] ref_addr_q, ref_addr_d, ref_din_q, ref_din_d;
  logic [31:0] def_addr_q, def_addr_d, def_din_q, def_din_d;
  logic [31:0] bram_full_q, bram_full_d;
  logic        res_en_q, res_en_d;
  logic [31:0] res_addr_q, res_addr_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic          s_hs, m_hs, issue;
  logic [7:0]    inflight, occ;
  logic [31:0]   fifo_dout;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  bram_rd_skid #(.W(32), .DEPTH(FIFO_DEPTH)) u_skid (
    .clock  (clock),
    .resetn (resetn),
    .push   (vld_q[RD_LAT-1]),
    .din    (res_dout),
    .pop    (m_hs),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign s_ready   = (state_q == ST_LOAD_REF) || (state_q == ST_LOAD_DEF);
  assign s_hs      = s_valid && s_ready;
  assign m_valid   = (state_q == ST_READ) && !fifo_empty;
  assign m_last    = m_valid && (out_idx_q == RD_LAST);
  assign m_data    = m_valid ? fifo_dout : '0;
  assign m_hs      = m_valid && m_ready;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  assign ref_en = ref_en_q;  assign ref_we = ref_we_q;
  assign ref_addr = ref_addr_q;  assign ref_din = ref_din_q;
  assign def_en = def_en_q;  assign def_we = def_we_q;
  assign def_addr = def_addr_q;  assign def_din = def_din_q;
  assign bram_full = bram_full_q;
  assign res_en = res_en_q;  assign res_addr = res_addr_q;

  always_comb begin
    inflight = 8'(res_en_q);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(vld_q[i]);
  end

  // A slot freed by this cycle's pop is reusable, which keeps full rate.
  assign occ   = 8'(fifo_count) + inflight - 8'(m_hs);
  assign issue = (state_q == ST_READ) && (rd_idx_q < RD_WORDS) && (occ < FIFO_LIM);

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = res_en_q;
  end

  always_comb begin
    state_d     = state_q;
    ld_idx_d    = ld_idx_q;
    rd_idx_d    = rd_idx_q;
    out_idx_d   = out_idx_q;
    ref_en_d    = 1'b0;
    ref_we_d    = 4'b0000;
    ref_addr_d  = ref_addr_q;
    ref_din_d   = ref_din_q;
    def_en_d    = 1'b0;
    def_we_d    = 4'b0000;
    def_addr_d  = def_addr_q;
    def_din_d   = def_din_q;
    bram_full_d = bram_full_q;
    res_en_d    = 1'b0;
    res_addr_d  = res_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD_REF;
          ld_idx_d = '0;
        end
      end
      ST_LOAD_REF: begin
        if (s_hs) begin
          ref_en_d   = 1'b1;
          ref_we_d   = WE_ALL;
          ref_addr_d = byte_addr(ld_idx_q);
          ref_din_d  = s_data;
          if (ld_idx_q == LD_LAST) begin
            ld_idx_d = '0;
            state_d  = ST_LOAD_DEF;
          end else begin
            ld_idx_d = ld_idx_q + 32'd1;
          end
        end
      end
      ST_LOAD_DEF: begin
        if (s_hs) begin
          def_en_d   = 1'b1;
          def_we_d   = WE_ALL;
          def_addr_d = byte_addr(ld_idx_q);
          def_din_d  = s_data;
          if (ld_idx_q == LD_LAST) begin
            ld_idx_d = '0;
            state_d  = ST_FULL;
          end else begin
            ld_idx_d = ld_idx_q + 32'd1;
          end
        end
      end
      ST_FULL: begin
        // Raised one cycle after the last def write is on the port.
        bram_full_d = BRAM_FULL_SET;
        if (compute_done) begin
          state_d   = ST_READ;
          rd_idx_d  = '0;
          out_idx_d = '0;
        end
      end
      ST_READ: begin
        if (issue) begin
          res_en_d   = 1'b1;
          res_addr_d = byte_addr(rd_idx_q);
          rd_idx_d   = rd_idx_q + 32'd1;
        end
        if (m_hs) begin
          if (m_last) begin
            state_d     = ST_IDLE;
            bram_full_d = BRAM_FULL_CLR;
            rd_idx_d    = '0;
            out_idx_d   = '0;
          end else begin
            out_idx_d = out_idx_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ld_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_idx_q   <= '0;
      ref_en_q    <= 1'b0;
      ref_we_q    <= 4'b0000;
      ref_addr_q  <= '0;
      ref_din_q   <= '0;
      def_en_q    <= 1'b0;
      def_we_q    <= 4'b0000;
      def_addr_q  <= '0;
      def_din_q   <= '0;
      bram_full_q <= BRAM_FULL_CLR;
      res_en_q    <= 1'b0;
      res_addr_q  <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      ld_idx_q    <= ld_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      ref_en_q    <= ref_en_d;
      ref_we_q    <= ref_we_d;
      ref_addr_q  <= ref_addr_d;
      ref_din_q   <= ref_din_d;
      def_en_q    <= def_en_d;
      def_we_q    <= def_we_d;
      def_addr_q  <= def_addr_d;
      def_din_q   <= def_din_d;
      bram_full_q <= bram_full_d;
      res_en_q    <= res_en_d;
      res_addr_q  <= res_addr_d;
      vld_q       <= vld_d;
    end
  end

endmodule

// File: tb/tb_bram_host_loader.sv
// Bench for bram_host_loader: three instances (read latency 1, 2, 4) share
// the stimulus; each has its own result-BRAM model and output scoreboard.
`timescale 1ns/1ps
module tb_bram_host_loader;
  import dice_pkg::*;

  localparam int DEPTH     = 16;
  localparam int RES_WORDS = 8;
  localparam int NI        = 3;

  logic        clock, resetn, start, s_valid, compute_done, m_ready;
  logic [31:0] s_data;

  logic        s_ready [NI];
  logic [31:0] ref_addr [NI], ref_din [NI], def_addr [NI], def_din [NI];
  logic [3:0]  ref_we [NI], def_we [NI];
  logic        ref_en [NI], def_en [NI];
  logic [31:0] bram_full [NI], res_addr [NI], res_dout [NI], m_data [NI];
  logic        res_en [NI], m_valid [NI], m_last [NI], busy [NI];
  logic [2:0]  dbg_state [NI];

  logic [31:0] res_mem [RES_WORDS];
  int issued [NI], outs [NI], first_cyc [NI], last_cyc [NI];
  logic        held_v [NI], held_l [NI];
  logic [31:0] held_d [NI];
  int cyc = 0;
  int entry_cyc = 0;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] pipe [4];

    bram_host_loader #(.DEPTH(DEPTH), .RES_WORDS(RES_WORDS), .RD_LAT(L)) u_dut (
      .clock(clock), .resetn(resetn), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[g]),
      .ref_addr(ref_addr[g]), .ref_din(ref_din[g]), .ref_we(ref_we[g]), .ref_en(ref_en[g]),
      .def_addr(def_addr[g]), .def_din(def_din[g]), .def_we(def_we[g]), .def_en(def_en[g]),
      .bram_full(bram_full[g]), .compute_done(compute_done),
      .res_addr(res_addr[g]), .res_en(res_en[g]), .res_dout(res_dout[g]),
      .m_data(m_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready), .m_last(m_last[g]),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );

    // Result BRAM: enable sampled at edge k, data visible for sampling at k+L.
    always @(posedge clock) begin
      if (res_en[g]) pipe[0] <= res_mem[res_addr[g][4:2]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign res_dout[g] = pipe[L-1];

    // Scoreboard: reads in order, bounded outstanding, ordered data, stable stalls.
    always @(negedge clock) begin
      if (resetn) begin
        if (res_en[g]) begin
          check($sformatf("res_addr[%0d]", g), res_addr[g], 32'(issued[g] * 4));
          issued[g]++;
          check($sformatf("outstanding[%0d]", g), 32'((issued[g] - outs[g]) <= L + 2), 32'd1);
        end
        if (held_v[g]) begin
          check($sformatf("hold_valid[%0d]", g), 32'(m_valid[g]), 32'd1);
          check($sformatf("hold_data[%0d]", g), m_data[g], held_d[g]);
          check($sformatf("hold_last[%0d]", g), 32'(m_last[g]), 32'(held_l[g]));
        end
        held_v[g] = m_valid[g] && !m_ready;
        held_d[g] = m_data[g];
        held_l[g] = m_last[g];
        if (m_valid[g] && m_ready) begin
          if (outs[g] >= RES_WORDS) begin
            check($sformatf("extra_word[%0d]", g), 32'd1, 32'd0);
          end else begin
            check($sformatf("m_data[%0d]", g), m_data[g], res_mem[outs[g]]);
            check($sformatf("m_last[%0d]", g), 32'(m_last[g]), 32'(outs[g] == RES_WORDS - 1));
          end
          if (outs[g] == 0) begin
            first_cyc[g] = cyc;
            check($sformatf("first_lat[%0d]", g), 32'((cyc - entry_cyc) >= L + 1), 32'd1);
          end
          last_cyc[g] = cyc;
          outs[g]++;
        end
      end
    end
  end

  task automatic check_reset_all(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_state[%0d]", tag, g), 32'(dbg_state[g]), 32'(ST_IDLE));
      check($sformatf("%s_s_ready[%0d]", tag, g), 32'(s_ready[g]), 32'd0);
      check($sformatf("%s_ref[%0d]", tag, g), ref_addr[g] | ref_din[g] | 32'(ref_we[g]) | 32'(ref_en[g]), 32'd0);
      check($sformatf("%s_def[%0d]", tag, g), def_addr[g] | def_din[g] | 32'(def_we[g]) | 32'(def_en[g]), 32'd0);
      check($sformatf("%s_bram_full[%0d]", tag, g), bram_full[g], 32'd0);
      check($sformatf("%s_res[%0d]", tag, g), res_addr[g] | 32'(res_en[g]), 32'd0);
      check($sformatf("%s_m[%0d]", tag, g), m_data[g] | 32'(m_valid[g]) | 32'(m_last[g]), 32'd0);
      check($sformatf("%s_busy[%0d]", tag, g), 32'(busy[g]), 32'd0);
    end
  endtask

  // Driver: streams 2*DEPTH words; abort_at >= 0 returns with that many accepted.
  task automatic run_load(input int stall, input bit poke, input int abort_at);
    logic [31:0] words [2*DEPTH];
    int i, n, idx;
    bit hs, is_def;
    logic [2:0] exp_state;
    for (int k = 0; k < 2 * DEPTH; k++) words[k] = $urandom;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int g = 0; g < NI; g++)
      check($sformatf("load_entry[%0d]", g), 32'(dbg_state[g]), 32'(ST_LOAD_REF));
    i = 0;
    while (i < 2 * DEPTH) begin
      if (i == abort_at) return;
      s_valid = ($urandom_range(0, 99) >= stall);
      s_data  = words[i];
      if (poke) begin
        start        = (i == DEPTH + 3);
        compute_done = (i == 2) || (i == DEPTH + 3);
      end
      @(posedge clock);
      hs = s_valid;
      #1;
      s_valid = 1'b0; start = 1'b0; compute_done = 1'b0;
      is_def = (i >= DEPTH);
      idx = i % DEPTH;
      n = i + 32'(hs);
      exp_state = (n == 2 * DEPTH) ? 3'(ST_FULL) : ((n >= DEPTH) ? 3'(ST_LOAD_DEF) : 3'(ST_LOAD_REF));
      for (int g = 0; g < NI; g++) begin
        check($sformatf("ref_en[%0d]", g), 32'(ref_en[g]), 32'(hs && !is_def));
        check($sformatf("def_en[%0d]", g), 32'(def_en[g]), 32'(hs && is_def));
        check($sformatf("load_state[%0d]", g), 32'(dbg_state[g]), 32'(exp_state));
        check($sformatf("s_ready[%0d]", g), 32'(s_ready[g]), 32'(n < 2 * DEPTH));
        check($sformatf("full_early[%0d]", g), bram_full[g], 32'd0);
        if (hs && !is_def) begin
          check($sformatf("ref_addr[%0d]", g), ref_addr[g], 32'(idx * 4));
          check($sformatf("ref_din[%0d]", g), ref_din[g], words[i]);
          check($sformatf("ref_we[%0d]", g), 32'(ref_we[g]), 32'hF);
        end
        if (hs && is_def) begin
          check($sformatf("def_addr[%0d]", g), def_addr[g], 32'(idx * 4));
          check($sformatf("def_din[%0d]", g), def_din[g], words[i]);
          check($sformatf("def_we[%0d]", g), 32'(def_we[g]), 32'hF);
        end
      end
      if (hs) i++;
    end
    @(posedge clock); #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("bram_full_set[%0d]", g), bram_full[g], 32'h1);
      check($sformatf("post_load_wr[%0d]", g), 32'(ref_en[g] | def_en[g]), 32'd0);
    end
  endtask

  // FULL: ignored stream input, then compute_done moves to READ.
  task automatic full_phase(input bit rdy);
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1; s_data = $urandom;
      @(posedge clock); #1;
      for (int g = 0; g < NI; g++) begin
        check($sformatf("full_s_ready[%0d]", g), 32'(s_ready[g]), 32'd0);
        check($sformatf("full_wr[%0d]", g), 32'(ref_en[g] | def_en[g]), 32'd0);
        check($sformatf("full_state[%0d]", g), 32'(dbg_state[g]), 32'(ST_FULL));
      end
    end
    s_valid = 1'b0;
    for (int k = 0; k < RES_WORDS; k++) res_mem[k] = $urandom;
    for (int g = 0; g < NI; g++) begin
      issued[g] = 0; outs[g] = 0; held_v[g] = 1'b0;
    end
    m_ready = rdy;
    compute_done = 1'b1;
    @(posedge clock); #1;
    entry_cyc = cyc;
    compute_done = 1'b0;
    for (int g = 0; g < NI; g++)
      check($sformatf("read_entry[%0d]", g), 32'(dbg_state[g]), 32'(ST_READ));
  endtask

  // mode 0: m_ready=1; mode 1: 10-cycle stall mid-read; mode 2: random m_ready.
  task automatic read_phase(input int mode);
    bit all_idle;
    all_idle = 1'b0;
    for (int c = 0; c < 300 && !all_idle; c++) begin
      if (mode == 1) m_ready = !(c >= 2 && c < 12);
      if (mode == 2) m_ready = ($urandom_range(0, 2) != 0);
      @(posedge clock); #1;
      if (mode == 1 && c == 11)
        for (int g = 0; g < NI; g++)
          check($sformatf("stall_res_en[%0d]", g), 32'(res_en[g]), 32'd0);
      all_idle = 1'b1;
      for (int g = 0; g < NI; g++) if (busy[g]) all_idle = 1'b0;
    end
    check("read_done", 32'(all_idle), 32'd1);
    m_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("word_count[%0d]", g), 32'(outs[g]), 32'(RES_WORDS));
      check($sformatf("end_state[%0d]", g), 32'(dbg_state[g]), 32'(ST_IDLE));
      check($sformatf("end_full[%0d]", g), bram_full[g], 32'd0);
      if (mode == 0)
        check($sformatf("throughput[%0d]", g), 32'(last_cyc[g] - first_cyc[g]), 32'(RES_WORDS - 1));
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    compute_done = 1'b0; m_ready = 1'b0;
    for (int g = 0; g < NI; g++) begin
      issued[g] = 0; outs[g] = 0; held_v[g] = 1'b0; first_cyc[g] = 0; last_cyc[g] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    check_reset_all("por");
    resetn = 1'b1;
    @(posedge clock); #1;

    run_load(0, 1'b1, -1);
    full_phase(1'b1);
    read_phase(0);

    run_load(50, 1'b0, -1);
    full_phase(1'b1);
    read_phase(1);

    run_load(0, 1'b0, DEPTH + 5);
    resetn = 1'b0;
    #1;
    check_reset_all("mid_rst");
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    run_load(30, 1'b0, -1);
    full_phase(1'b0);
    read_phase(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
